// File: rtl/wb_byte_master_pkg.sv
// Shared constants for the byte-wide classic Wishbone master: FSM states,
// response status codes and the fixed cycle-type tags.
package wb_byte_master_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_ERR     = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;
  localparam logic [1:0] ST_RTY     = 2'd3;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Counts bus wait cycles; expired is raised combinationally on the wait cycle
// that brings the count to TIMEOUT_CYCLES. TIMEOUT_CYCLES=0 disables it.
module wb_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

      logic [CW-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
          cnt_d = '0;
        end else if (enable) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      // Fires in the same cycle as the final wait so the abort lands on that edge.
      assign expired = enable && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule

// File: rtl/wb_byte_master.sv
// Single-outstanding classic Wishbone B3 byte master with timeout and
// err > rty > ack termination priority. Optional reissue on rty: WB_MASTER_RETRY_EN.
module wb_byte_master #(
  parameter int unsigned WB_ADR_WIDTH   = 3,
  parameter int unsigned WB_DAT_WIDTH   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic                    wb_clk,
  input  logic                    wb_rst,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [WB_ADR_WIDTH-1:0] req_adr_i,
  input  logic [WB_DAT_WIDTH-1:0] req_dat_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [WB_DAT_WIDTH-1:0] rsp_dat_o,
  output logic [1:0]              rsp_status_o,
  output logic [WB_ADR_WIDTH-1:0] wb_adr_o,
  output logic [WB_DAT_WIDTH-1:0] wb_dat_o,
  output logic                    wb_we_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic [2:0]              wb_cti_o,
  output logic [1:0]              wb_bte_o,
  input  logic [WB_DAT_WIDTH-1:0] wb_dat_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  input  logic                    wb_rty_i
);
  import wb_byte_master_pkg::*;

  logic [1:0]              state_q, state_d;
  logic [WB_ADR_WIDTH-1:0] adr_q, adr_d;
  logic [WB_DAT_WIDTH-1:0] dat_q, dat_d;
  logic                    we_q, we_d;
  logic                    cyc_q, cyc_d;
  logic                    stb_q, stb_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [WB_DAT_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
  logic [1:0]              rsp_status_q, rsp_status_d;
  logic                    bus_wait;
  logic                    tmo_expired;

`ifdef WB_MASTER_RETRY_EN
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] retry_q, retry_d;
`endif

  assign bus_wait = (state_q == S_BUS) && !(wb_ack_i || wb_err_i || wb_rty_i);

  wb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (wb_clk),
    .rst    (wb_rst),
    .clear  (state_q != S_BUS),
    .enable (bus_wait),
    .expired(tmo_expired)
  );

  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    we_d         = we_q;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;
`ifdef WB_MASTER_RETRY_EN
    retry_d      = retry_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          adr_d   = req_adr_i;
          dat_d   = req_dat_i;
          we_d    = req_we_i;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          state_d = S_BUS;
        end
      end

      S_BUS: begin
        // Any exit from BUS drops cyc/stb on the same edge.
        if (wb_err_i || wb_rty_i || wb_ack_i || tmo_expired) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = '0;
          state_d     = S_RESP;
          if (wb_err_i) begin
            rsp_status_d = ST_ERR;
          end else if (wb_rty_i) begin
            rsp_status_d = ST_RTY;
`ifdef WB_MASTER_RETRY_EN
            if (retry_q < RW'(MAX_RETRY)) begin
              rsp_valid_d = 1'b0;
              retry_d     = retry_q + RW'(1);
              state_d     = S_GAP;
            end
`endif
          end else if (wb_ack_i) begin
            rsp_status_d = ST_OK;
            rsp_dat_d    = we_q ? '0 : wb_dat_i;
          end else begin
            rsp_status_d = ST_TIMEOUT;
          end
        end
      end

`ifdef WB_MASTER_RETRY_EN
      S_GAP: begin
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        state_d = S_BUS;
      end
`endif

      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
`ifdef WB_MASTER_RETRY_EN
          retry_d     = '0;
`endif
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q      <= S_IDLE;
      adr_q        <= '0;
      dat_q        <= '0;
      we_q         <= 1'b0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= ST_OK;
    end else begin
      state_q      <= state_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      we_q         <= we_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
    end
  end

`ifdef WB_MASTER_RETRY_EN
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      retry_q <= '0;
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

  assign req_ready_o  = (state_q == S_IDLE);
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_dat_o    = rsp_dat_q;
  assign rsp_status_o = rsp_status_q;
  assign wb_adr_o     = adr_q;
  assign wb_dat_o     = dat_q;
  assign wb_we_o      = we_q;
  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = stb_q;
  assign wb_cti_o     = CTI_CLASSIC;
  assign wb_bte_o     = BTE_LINEAR;

endmodule

// File: doc/wb_byte_master.md
Name: wb_byte_master

Overview:
- Single-outstanding classic Wishbone B3 master with byte-wide data, the initiator counterpart to the team's 8-bit peripheral slaves (GPIO, UART, etc.).
- Converts a valid/ready request stream (from a debug bridge, boot sequencer or test harness) into one single-beat cycle at a time.
- Returns read data plus a completion status on a valid/ready response stream.
- Adds bus-timeout detection and termination-priority handling so a hung or absent slave cannot stall the requester.

Parameters:
- WB_ADR_WIDTH, 3, width of wb_adr_o and req_adr_i
- WB_DAT_WIDTH, 8, data width; fixed at 8, other values unsupported
- TIMEOUT_CYCLES, 16, max cycles stb may stay high without termination; 0 disables timeout
- MAX_RETRY, 3, reissue limit on rty (used only with WB_MASTER_RETRY_EN)

Ports:
- wb_clk  in  1  clock
- wb_rst  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  request present
- req_ready_o  out  1  master can accept request
- req_we_i  in  1  1=write, 0=read
- req_adr_i  in  WB_ADR_WIDTH  target address
- req_dat_i  in  8  write data
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  requester consumes response
- rsp_dat_o  out  8  read data
- rsp_status_o  out  2  0=OK, 1=ERR, 2=TIMEOUT, 3=RTY
- wb_adr_o  out  WB_ADR_WIDTH  bus address
- wb_dat_o  out  8  bus write data
- wb_we_o  out  1  bus write enable
- wb_cyc_o  out  1  cycle
- wb_stb_o  out  1  strobe
- wb_cti_o  out  3  constant 3'b000 (classic)
- wb_bte_o  out  2  constant 2'b00
- wb_dat_i  in  8  bus read data
- wb_ack_i  in  1  normal termination
- wb_err_i  in  1  error termination
- wb_rty_i  in  1  retry termination

Behaviour:
- Reset is asynchronous and active-high.
  - All registered outputs go to 0: cyc, stb, we, adr, dat, rsp_valid, rsp_dat, rsp_status.
  - FSM goes to IDLE; timeout and retry counters clear.
  - Reset mid-cycle drops cyc/stb immediately and discards any pending response.
- FSM states: IDLE, BUS, GAP, RESP.
- IDLE:
  - req_ready_o=1 only in IDLE.
  - On req_valid_i&req_ready_o, latch we/adr/dat into wb_*_o, assert cyc=stb=1 at the same edge, go to BUS.
  - Bus is active the cycle after acceptance.
- BUS:
  - Outputs held stable.
  - Termination is sampled on each rising edge; priority is err > rty > ack when asserted together.
  - ack: capture wb_dat_i into rsp_dat_o for reads, 0 for writes; status 0.
  - err: status 1, rsp_dat_o=0.
  - rty: status 3, rsp_dat_o=0, unless the retry feature is enabled (see Optional Feature).
  - On any termination, deassert cyc/stb at that same edge, set rsp_valid_o=1 and go to RESP.
  - Minimum request-to-response latency is 2 cycles for a slave that acks the cycle after stb.
  - Timeout counter increments each BUS cycle with no termination. When it equals TIMEOUT_CYCLES, abort: drop cyc/stb, status 2, go to RESP.
  - A termination arriving on the abort cycle wins over timeout.
- RESP:
  - rsp_valid_o held with stable data/status until rsp_ready_i.
  - On handshake, clear rsp_valid_o and go to IDLE.
  - Back-to-back throughput is therefore at most one transaction per 3 cycles.
  - cyc/stb are low for at least one cycle between transactions, which guarantees slaves that self-clear ack never see a double ack.
- Stray ack/err/rty outside BUS is ignored.

Optional Feature:
- Macro: WB_MASTER_RETRY_EN.
- Defined:
  - rty with retry count < MAX_RETRY: drop cyc/stb, go to GAP for one cycle, then reassert with the same adr/dat/we.
  - Retry count increments and the timeout counter clears on each reissue.
  - rty when count == MAX_RETRY: status 3.
  - Retry count clears on leaving RESP.
- Undefined: rty terminates immediately with status 3; GAP state and retry counter not synthesised.

Decomposition:
- Package wb_byte_master_pkg holds:
  - state enum (IDLE, BUS, GAP, RESP)
  - status constants ST_OK, ST_ERR, ST_TIMEOUT, ST_RTY
  - CTI_CLASSIC and BTE_LINEAR constants
- Sub-module wb_timeout_cnt holds the TIMEOUT_CYCLES counter.
  - Inputs: clear, enable. Output: expired.
  - Width $clog2(TIMEOUT_CYCLES+1); expired tied 0 when TIMEOUT_CYCLES=0.
- FSM, datapath and retry logic stay in the top module.

Test Plan:
- Write 0xA5 to adr 3, slave acks the cycle after stb -> exactly one ack cycle seen; rsp_valid_o 2 cycles after acceptance; status 0; cyc/stb low the following cycle.
- Read adr 3 after that write, slave returns 0xA5 -> rsp_dat_o=0xA5, status 0; hold rsp_ready_i low 5 cycles -> response stable and req_ready_o=0 throughout.
- No slave response, TIMEOUT_CYCLES=16 -> stb high exactly 16 cycles, then status 2; ack injected on cycle 16 -> status 0 instead.
- ack and err asserted together -> status 1, rsp_dat_o=0.
- rty three times then ack: with WB_MASTER_RETRY_EN and MAX_RETRY=3 -> 4 bus cycles, each separated by one idle cycle, status 0; without the macro -> 1 bus cycle, status 3.
- Assert wb_rst while stb is high -> cyc/stb low before the next clock edge, no rsp_valid_o; a new request is accepted normally after release.
